// File: rtl/elevator_request_scheduler.sv
// SCAN-policy request scheduler for the elevator controller.
// Synchronizes raw call buttons, latches them as pending requests, picks the
// next floor in the current sweep direction, and holds the door open for a
// fixed dwell once the car stops at the served floor.
//
// state | meaning
// ------+---------------------------------------------------------------
// WAIT  | no work, or car still moving; requested_floor holds
// PICK  | one cycle: choose next target from pending, floor, direction
// SERVE | target presented; wait for the car to stop at it
// DWELL | door open for DWELL_CYCLES, then clear the served request
module elevator_request_scheduler #(
    parameter int          NUM_FLOORS   = 10,
    parameter int          FLOOR_W      = 4,
    parameter logic [31:0] DWELL_CYCLES = 32'd20000000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] call_buttons,
    input  logic [FLOOR_W-1:0]    current_floor,
    input  logic                  idle,
    output logic [FLOOR_W-1:0]    requested_floor,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  door_open,
    output logic                  dir_up
);

    typedef enum logic [1:0] {WAIT, PICK, SERVE, DWELL} state_t;

    state_t                state, state_nxt;
    logic [NUM_FLOORS-1:0] sync1, sync2, sync3;
    logic [NUM_FLOORS-1:0] btn_edge, served_mask, clr_mask, ign_mask, pending_nxt;
    logic [31:0]           dwell_cnt, dwell_cnt_nxt;
    logic [FLOOR_W-1:0]    req_nxt, pick_floor;
    logic                  dir_nxt, door_nxt, pick_dir, pick_valid;

    assign btn_edge    = sync2 & ~sync3;
    assign served_mask = NUM_FLOORS'(1) << requested_floor;

    // Two-flop synchronizer plus a third flop for rising-edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
            sync3 <= '0;
        end else begin
            sync1 <= call_buttons;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    // SCAN target selection; an out-of-range current_floor compares as above every floor.
    always_comb begin
        int  cur;
        int  up_f, below_f, dn_f, above_f;
        logic up_hit, below_hit, dn_hit, above_hit;
        cur       = 32'(current_floor);
        up_f      = 0;
        below_f   = 0;
        dn_f      = 0;
        above_f   = 0;
        up_hit    = 1'b0;
        below_hit = 1'b0;
        dn_hit    = 1'b0;
        above_hit = 1'b0;
        for (int f = NUM_FLOORS - 1; f >= 0; f--) begin
            if (pending[f] && f >= cur) begin up_hit = 1'b1; up_f = f; end
            if (pending[f] && f > cur)  begin above_hit = 1'b1; above_f = f; end
        end
        for (int f = 0; f < NUM_FLOORS; f++) begin
            if (pending[f] && f < cur)  begin below_hit = 1'b1; below_f = f; end
            if (pending[f] && f <= cur) begin dn_hit = 1'b1; dn_f = f; end
        end
        pick_floor = '0;
        pick_dir   = dir_up;
        pick_valid = 1'b0;
        if (dir_up) begin
            if (up_hit) begin
                pick_floor = FLOOR_W'(up_f);
                pick_valid = 1'b1;
            end else if (below_hit) begin
                pick_floor = FLOOR_W'(below_f);
                pick_dir   = 1'b0;
                pick_valid = 1'b1;
            end
        end else begin
            if (dn_hit) begin
                pick_floor = FLOOR_W'(dn_f);
                pick_valid = 1'b1;
            end else if (above_hit) begin
                pick_floor = FLOOR_W'(above_f);
                pick_dir   = 1'b1;
                pick_valid = 1'b1;
            end
        end
    end

    // Next-state, target, direction, dwell timer and pending update.
    always_comb begin
        state_nxt     = state;
        req_nxt       = requested_floor;
        dir_nxt       = dir_up;
        dwell_cnt_nxt = dwell_cnt;
        clr_mask      = '0;
        ign_mask      = '0;
        case (state)
            WAIT: begin
                if (|pending && idle) state_nxt = PICK;
            end
            PICK: begin
                if (pick_valid) begin
                    req_nxt   = pick_floor;
                    dir_nxt   = pick_dir;
                    state_nxt = SERVE;
                end else begin
                    state_nxt = WAIT;
                end
            end
            SERVE: begin
                if (idle && current_floor == requested_floor) begin
                    state_nxt     = DWELL;
                    dwell_cnt_nxt = DWELL_CYCLES - 32'd1;
                end
            end
            DWELL: begin
                ign_mask = served_mask;
                if (dwell_cnt == 32'd0) begin
                    clr_mask  = served_mask;
                    state_nxt = |(pending & ~served_mask) ? PICK : WAIT;
                end else begin
                    dwell_cnt_nxt = dwell_cnt - 32'd1;
                end
            end
            default: state_nxt = WAIT;
        endcase
        pending_nxt = (pending & ~clr_mask) | (btn_edge & ~ign_mask);
        door_nxt    = (state_nxt == DWELL);
    end

    // Registered state and outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= WAIT;
            requested_floor <= '0;
            pending         <= '0;
            door_open       <= 1'b0;
            dir_up          <= 1'b1;
            dwell_cnt       <= '0;
        end else begin
            state           <= state_nxt;
            requested_floor <= req_nxt;
            pending         <= pending_nxt;
            door_open       <= door_nxt;
            dir_up          <= dir_nxt;
            dwell_cnt       <= dwell_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_elevator_request_scheduler.sv
// Directed bench for elevator_request_scheduler with a behavioural car that
// moves one floor every 8 cycles toward requested_floor.
module tb_elevator_request_scheduler;

    localparam int NF = 10;
    localparam int FW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [NF-1:0] call_buttons = '0;
    logic [FW-1:0] current_floor;
    logic          idle;
    logic [FW-1:0] requested_floor;
    logic [NF-1:0] pending;
    logic          door_open;
    logic          dir_up;

    int n_checks = 0;
    int n_pass   = 0;
    int door_cnt = 0;
    int viol     = 0;

    logic [FW-1:0] el_floor = '0;
    int            mv_cnt = 0;
    logic          tp_en = 1'b0;
    logic [FW-1:0] tp_floor = '0;

    elevator_request_scheduler #(
        .NUM_FLOORS(NF), .FLOOR_W(FW), .DWELL_CYCLES(32'd4)
    ) dut (
        .clk(clk), .reset(reset), .call_buttons(call_buttons),
        .current_floor(current_floor), .idle(idle),
        .requested_floor(requested_floor), .pending(pending),
        .door_open(door_open), .dir_up(dir_up)
    );

    always #5 clk = ~clk;

    assign current_floor = el_floor;
    assign idle          = (el_floor == requested_floor);

    // Car model: one floor per 8 cycles toward the request.
    always @(posedge clk) begin
        if (tp_en) begin
            el_floor <= tp_floor;
            mv_cnt   <= 0;
        end else if (el_floor != requested_floor) begin
            if (mv_cnt == 7) begin
                mv_cnt   <= 0;
                el_floor <= (el_floor < requested_floor) ? el_floor + 4'd1 : el_floor - 4'd1;
            end else begin
                mv_cnt <= mv_cnt + 1;
            end
        end else begin
            mv_cnt <= 0;
        end
    end

    // Watch for requested_floor changing while the car was moving.
    logic [FW-1:0] last_req = '0;
    logic          last_idle = 1'b1;
    logic          have_last = 1'b0;
    always @(posedge clk) begin
        if (reset) begin
            have_last = 1'b0;
        end else begin
            if (have_last && requested_floor != last_req && !last_idle) viol++;
            have_last = 1'b1;
        end
        last_req  = requested_floor;
        last_idle = idle;
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (door_open) door_cnt++;
    endtask

    task automatic do_reset(input int floor);
        reset    = 1'b1;
        tp_en    = 1'b1;
        tp_floor = FW'(floor);
        step();
        step();
        tp_en = 1'b0;
        reset = 1'b0;
    endtask

    task automatic press(input int floor);
        call_buttons = NF'(1) << floor;
        step();
        call_buttons = '0;
    endtask

    task automatic wait_door_open(input string tag, input int floor, input int dir);
        int n = 0;
        while (!door_open && n < 600) begin
            step();
            n++;
        end
        chk({tag, "_door_timeout"}, int'(door_open), 1);
        door_cnt = 1;
        chk({tag, "_car_floor"}, int'(el_floor), floor);
        chk({tag, "_req_floor"}, int'(requested_floor), floor);
        chk({tag, "_dir_up"}, int'(dir_up), dir);
    endtask

    task automatic finish_dwell(input string tag);
        int n = 0;
        while (door_open && n < 100) begin
            step();
            n++;
        end
        chk({tag, "_dwell_len"}, door_cnt, 4);
    endtask

    initial begin
        // Reset state
        do_reset(0);
        chk("rst_req", int'(requested_floor), 0);
        chk("rst_pending", int'(pending), 0);
        chk("rst_door", int'(door_open), 0);
        chk("rst_dir", int'(dir_up), 1);

        // Single pulse on floor 3: capture latency and request latency
        call_buttons = NF'(1) << 3;
        step();
        call_buttons = '0;
        step();
        chk("s1_pend_e2", int'(pending), 0);
        step();
        chk("s1_pend_e3", int'(pending), 'h008);
        step();
        chk("s1_req_e4", int'(requested_floor), 0);
        step();
        chk("s1_req_e5", int'(requested_floor), 3);
        wait_door_open("s1", 3, 1);
        finish_dwell("s1");
        chk("s1_pend_end", int'(pending), 0);

        // From floor 0: 7 then 2 -> serve 2 then 7, still going up
        do_reset(0);
        call_buttons = NF'(1) << 7;
        step();
        call_buttons = NF'(1) << 2;
        step();
        call_buttons = '0;
        wait_door_open("s2a", 2, 1);
        finish_dwell("s2a");
        wait_door_open("s2b", 7, 1);
        finish_dwell("s2b");
        chk("s2_pend_end", int'(pending), 0);

        // At floor 5 going up with 8 and 1 pending -> 8, flip, then 1
        do_reset(0);
        press(5);
        wait_door_open("s3a", 5, 1);
        call_buttons = (NF'(1) << 8) | (NF'(1) << 1);
        step();
        call_buttons = '0;
        finish_dwell("s3a");
        wait_door_open("s3b", 8, 1);
        finish_dwell("s3b");
        wait_door_open("s3c", 1, 0);
        finish_dwell("s3c");

        // Stationary at 4, press 4 (held): SERVE goes straight to DWELL
        do_reset(0);
        press(4);
        wait_door_open("s4a", 4, 1);
        finish_dwell("s4a");
        call_buttons = NF'(1) << 4;
        step();
        step();
        step();
        chk("s4_pend_e3", int'(pending), 'h010);
        step();
        step();
        chk("s4_door_e5", int'(door_open), 0);
        chk("s4_req_e5", int'(requested_floor), 4);
        step();
        chk("s4_door_e6", int'(door_open), 1);
        door_cnt = 1;
        finish_dwell("s4b");
        chk("s4_no_move", int'(el_floor), 4);
        chk("s4_held_once", int'(pending), 0);
        call_buttons = '0;

        // Floor 6 pressed during its own dwell is ignored; 2 set as 6 clears
        press(6);
        wait_door_open("s5a", 6, 1);
        call_buttons = NF'(1) << 6;
        step();
        call_buttons = NF'(1) << 2;
        step();
        call_buttons = '0;
        step();
        step();
        chk("s5_pend_swap", int'(pending), 'h004);
        chk("s5_door_closed", int'(door_open), 0);
        chk("s5a_dwell_len", door_cnt, 4);
        wait_door_open("s5b", 2, 0);
        finish_dwell("s5b");
        chk("s5_pend_end", int'(pending), 0);

        // Reset mid-trip toward 9, then a fresh request is served
        press(9);
        press(1);
        for (int i = 0; i < 30; i++) step();
        chk("s6_moving", int'(idle), 0);
        chk("s6_req_pre", int'(requested_floor), 9);
        reset = 1'b1;
        #1;
        chk("s6_rst_req", int'(requested_floor), 0);
        chk("s6_rst_pend", int'(pending), 0);
        chk("s6_rst_door", int'(door_open), 0);
        chk("s6_rst_dir", int'(dir_up), 1);
        step();
        step();
        reset = 1'b0;
        press(1);
        step();
        step();
        chk("s6_pend_new", int'(pending), 'h002);
        wait_door_open("s6", 1, 1);
        finish_dwell("s6");
        chk("s6_pend_end", int'(pending), 0);

        chk("req_stable_while_moving", viol, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
